// File: rtl/blit_write_fifo.sv
// Show-ahead write FIFO between the blit combine stage and the SDRAM arbiter.
// Optional tail-merge of same-word writes is enabled by defining BLIT_WFIFO_MERGE_EN.
module blit_write_fifo #(
  parameter int DEPTH       = 8,
  parameter int STALL_LEVEL = DEPTH - 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     p5_write,
  input  logic [25:0]              p5_address,
  input  logic [3:0]               p5_wstrb,
  input  logic [31:0]              p5_wdata,
  output logic                     stall,
  output logic                     mem_request,
  output logic [25:0]              mem_address,
  output logic [3:0]               mem_wstrb,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] STALL_LVL = LW'(STALL_LEVEL);
  localparam logic [LW-1:0] ONE_LVL   = LW'(1);
  localparam logic [PW-1:0] ONE_PTR   = PW'(1);

  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic [23:0] addrMem_q [DEPTH];
  logic [3:0]  strbMem_q [DEPTH];
  logic [31:0] dataMem_q [DEPTH];

  logic [PW-1:0] tailPtr;
  logic          wrValid;
  logic          doPop;
  logic          doPush;
  logic          doMerge;
  logic          unusedAddrBits;

  assign unusedAddrBits = ^p5_address[1:0];
  assign tailPtr        = wrPtr_q - ONE_PTR;

  always_comb begin
    wrValid    = p5_write && (p5_wstrb != 4'b0000);
    doPop      = (level_q != '0) && mem_ready;
    doMerge    = 1'b0;
`ifdef BLIT_WFIFO_MERGE_EN
    // Level>=2 keeps the tail distinct from the head under handshake.
    doMerge    = wrValid && (level_q > ONE_LVL) &&
                 (addrMem_q[tailPtr] == p5_address[25:2]);
`else
    doMerge    = 1'b0;
`endif
    doPush     = wrValid && !doMerge && ((level_q != FULL_LVL) || doPop);
    overflow_d = overflow_q || (wrValid && !doMerge && !doPush);
    rdPtr_d    = doPop  ? rdPtr_q + ONE_PTR : rdPtr_q;
    wrPtr_d    = doPush ? wrPtr_q + ONE_PTR : wrPtr_q;
    level_d    = level_q;
    if (doPush && !doPop) begin
      level_d = level_q + ONE_LVL;
    end else if (doPop && !doPush) begin
      level_d = level_q - ONE_LVL;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (doPush) begin
      addrMem_q[wrPtr_q] <= p5_address[25:2];
      strbMem_q[wrPtr_q] <= p5_wstrb;
      dataMem_q[wrPtr_q] <= p5_wdata;
    end else if (doMerge) begin
      strbMem_q[tailPtr] <= strbMem_q[tailPtr] | p5_wstrb;
      for (int b = 0; b < 4; b++) begin
        if (p5_wstrb[b]) begin
          dataMem_q[tailPtr][8*b +: 8] <= p5_wdata[8*b +: 8];
        end
      end
    end
  end

  assign mem_request = (level_q != '0);
  assign mem_address = mem_request ? {addrMem_q[rdPtr_q], 2'b00} : '0;
  assign mem_wstrb   = mem_request ? strbMem_q[rdPtr_q] : '0;
  assign mem_wdata   = mem_request ? dataMem_q[rdPtr_q] : '0;
  assign fifo_level  = level_q;
  assign stall       = (level_q >= STALL_LVL);
  assign overflow    = overflow_q;
  assign idle        = (level_q == '0);

endmodule

// File: tb/tb_blit_write_fifo.sv
// Self-checking bench for blit_write_fifo: constant vector table, directed corner
// sequences and randomized traffic checked against a queue-based reference model.
module tb_blit_write_fifo;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          p5_write = 1'b0;
  logic [25:0]   p5_address = '0;
  logic [3:0]    p5_wstrb = '0;
  logic [31:0]   p5_wdata = '0;
  logic          stall;
  logic          mem_request;
  logic [25:0]   mem_address;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          idle;

  int compared   = 0;
  int mismatched = 0;

  blit_write_fifo #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .p5_write    (p5_write),
    .p5_address  (p5_address),
    .p5_wstrb    (p5_wstrb),
    .p5_wdata    (p5_wdata),
    .stall       (stall),
    .mem_request (mem_request),
    .mem_address (mem_address),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .idle        (idle)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: an ordered list of pending word writes plus a sticky drop flag.
  typedef struct {
    logic [23:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } entry_t;

  entry_t mq[$];
  bit     mOvf;

  typedef struct {
    logic        w;
    logic [25:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        r;
    int          expLevel;
    logic        expStall;
    logic        expOvf;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[18];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOvf = 1'b0;
  endtask

  task automatic modelStep(input logic w, input logic [25:0] a, input logic [3:0] s,
                           input logic [31:0] d, input logic r);
    int     lvl = mq.size();
    bit     pop = (lvl != 0) && r;
    bit     valid = w && (s != 4'b0000);
    bit     merged = 1'b0;
    entry_t t;
`ifdef BLIT_WFIFO_MERGE_EN
    if (valid && lvl >= 2 && mq[lvl-1].a == a[25:2]) begin
      t = mq[lvl-1];
      t.s = t.s | s;
      for (int b = 0; b < 4; b++) if (s[b]) t.d[8*b +: 8] = d[8*b +: 8];
      mq[lvl-1] = t;
      merged = 1'b1;
    end
`endif
    if (pop) void'(mq.pop_front());
    if (valid && !merged) begin
      if (lvl < DEPTH || pop) begin
        t.a = a[25:2];
        t.s = s;
        t.d = d;
        mq.push_back(t);
      end else begin
        mOvf = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [25:0] a, input logic [3:0] s,
                               input logic [31:0] d, input logic r);
    @(negedge clock);
    p5_write   = w;
    p5_address = a;
    p5_wstrb   = s;
    p5_wdata   = d;
    mem_ready  = r;
    @(posedge clock);
    modelStep(w, a, s, d, r);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    int lvl = mq.size();
    cmp({tag, ".level"},    32'(fifo_level),  32'(lvl));
    cmp({tag, ".request"},  32'(mem_request), 32'(lvl != 0));
    cmp({tag, ".stall"},    32'(stall),       32'(lvl >= DEPTH - 2));
    cmp({tag, ".idle"},     32'(idle),        32'(lvl == 0));
    cmp({tag, ".overflow"}, 32'(overflow),    32'(mOvf));
    if (lvl != 0) begin
      cmp({tag, ".address"}, 32'(mem_address), 32'({mq[0].a, 2'b00}));
      cmp({tag, ".wstrb"},   32'(mem_wstrb),   32'(mq[0].s));
      cmp({tag, ".wdata"},   mem_wdata,        mq[0].d);
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n  = 1'b0;
    p5_write = 1'b0;
    mem_ready = 1'b0;
    #1;
    modelReset();
    cmp("reset.level",   32'(fifo_level),  32'd0);
    cmp("reset.request", 32'(mem_request), 32'd0);
    cmp("reset.idle",    32'(idle),        32'd1);
    cmp("reset.stall",   32'(stall),       32'd0);
    cmp("reset.overflow",32'(overflow),    32'd0);
    cmp("reset.address", 32'(mem_address), 32'd0);
    cmp("reset.wdata",   mem_wdata,        32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    modelReset();
    // Fill to full with ready low, drop a ninth write, then drain in order.
    for (int i = 0; i < 9; i++) begin
      vecs[i] = '{w: 1'b1, a: 26'(32'h1000 + 4*i), s: 4'hF, d: 32'h100 + 32'(i), r: 1'b0,
                  expLevel: (i < 8) ? i + 1 : 8, expStall: ((i + 1) >= 6),
                  expOvf: (i == 8), expData: 32'h100};
    end
    for (int k = 1; k <= 8; k++) begin
      vecs[8+k] = '{w: 1'b0, a: '0, s: 4'h0, d: '0, r: 1'b1,
                    expLevel: 8 - k, expStall: ((8 - k) >= 6),
                    expOvf: 1'b1, expData: 32'h100 + 32'(k)};
    end
    vecs[17] = '{w: 1'b1, a: 26'h2000, s: 4'h0, d: 32'hDEAD, r: 1'b1,
                 expLevel: 0, expStall: 1'b0, expOvf: 1'b1, expData: 32'h0};

    doReset();

    // Single write into an empty FIFO, visible one cycle later, then popped.
    applyStimulus(1'b1, 26'h0000100, 4'b0011, 32'h0000ABCD, 1'b1);
    cmp("single.request", 32'(mem_request), 32'd1);
    cmp("single.address", 32'(mem_address), 32'h100);
    cmp("single.wstrb",   32'(mem_wstrb),   32'h3);
    cmp("single.wdata",   mem_wdata,        32'h0000ABCD);
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1);
    cmp("single.drained", 32'(fifo_level), 32'd0);
    cmp("single.idle",    32'(idle),       32'd1);

    doReset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, vecs[i].r);
      cmp($sformatf("vec%0d.level", i),    32'(fifo_level), 32'(vecs[i].expLevel));
      cmp($sformatf("vec%0d.stall", i),    32'(stall),      32'(vecs[i].expStall));
      cmp($sformatf("vec%0d.overflow", i), 32'(overflow),   32'(vecs[i].expOvf));
      cmp($sformatf("vec%0d.idle", i),     32'(idle),       32'(vecs[i].expLevel == 0));
      if (vecs[i].expLevel != 0) cmp($sformatf("vec%0d.wdata", i), mem_wdata, vecs[i].expData);
    end

    // Write while full and popping in the same cycle must not drop.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 26'(32'h3000 + 4*i), 4'hF, 32'h500 + 32'(i), 1'b0);
    applyStimulus(1'b1, 26'h3100, 4'hF, 32'h5FF, 1'b1);
    cmp("fullpop.level",    32'(fifo_level), 32'd8);
    cmp("fullpop.overflow", 32'(overflow),   32'd0);
    cmp("fullpop.head",     mem_wdata,       32'h501);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, 4'h0, '0, 1'b1);
      checkOutput($sformatf("fullpop.drain%0d", i));
    end

    // Same-word writes: merged into the tail when enabled, separate entries otherwise.
    doReset();
    applyStimulus(1'b1, 26'h200, 4'b0001, 32'h11,   1'b0);
    applyStimulus(1'b1, 26'h300, 4'b1111, 32'h0,    1'b0);
    applyStimulus(1'b1, 26'h300, 4'b0010, 32'h2200, 1'b0);
`ifdef BLIT_WFIFO_MERGE_EN
    cmp("merge.level", 32'(fifo_level), 32'd2);
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1);
    cmp("merge.tailstrb", 32'(mem_wstrb), 32'hF);
    cmp("merge.taildata", mem_wdata,      32'h00002200);
`else
    cmp("merge.level", 32'(fifo_level), 32'd3);
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1);
    cmp("merge.secondstrb", 32'(mem_wstrb), 32'hF);
    cmp("merge.seconddata", mem_wdata,      32'h0);
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1);
    cmp("merge.thirdstrb", 32'(mem_wstrb), 32'h2);
    cmp("merge.thirddata", mem_wdata,      32'h2200);
`endif

    // Asynchronous reset mid-handshake discards everything immediately.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 26'(32'h4000 + 4*i), 4'hF, 32'h700 + 32'(i), 1'b0);
    cmp("midreset.prelevel", 32'(fifo_level), 32'd5);
    #2;
    mem_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    modelReset();
    cmp("midreset.request", 32'(mem_request), 32'd0);
    cmp("midreset.level",   32'(fifo_level),  32'd0);
    cmp("midreset.idle",    32'(idle),        32'd1);
    cmp("midreset.address", 32'(mem_address), 32'd0);
    cmp("midreset.wstrb",   32'(mem_wstrb),   32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1);
    cmp("midreset.after", 32'(fifo_level), 32'd0);
    checkOutput("midreset.model");

    // Randomized traffic over a few word addresses so merges and overflow both occur.
    doReset();
    for (int c = 0; c < 400; c++) begin
      logic        w;
      logic [25:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      logic        r;
      w = ($urandom_range(0, 99) < 60);
      a = 26'(32'h400 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3));
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      r = ($urandom_range(0, 99) < 45);
      applyStimulus(w, a, s, d, r);
      checkOutput($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
